// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial BCD adder, LSD first, start/busy/done handshake; BCD_SUB_EN adds nine's-complement subtract
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic              cin,
`ifdef BCD_SUB_EN
  input  logic              sub,
`endif
  output logic              busy,
  output logic              done,
  output logic [4*DIGITS-1:0] sum,
  output logic              cout,
  output logic              invalid
);
  localparam int KW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [4*DIGITS-1:0] ra, rb;
  logic carry, rsub, cin_in, accept, last, hi, bad, c;
  logic [3:0] ad, bo, bd, dig;
  logic [4:0] t5;
`ifdef BCD_SUB_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) rsub <= 1'b0;
    else if (accept) rsub <= sub;
  assign cin_in = sub | cin;
`else
  assign rsub = 1'b0;
  assign cin_in = cin;
`endif
  assign accept = start && state != RUN;
  assign last = k == KW'(DIGITS - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    ad = ra[4*k +: 4];
    bo = rb[4*k +: 4];
    bd = rsub ? 4'd9 - bo : bo;
    t5 = {1'b0, ad} + {1'b0, bd} + {4'b0, carry};
    hi = t5 >= 5'd10;
    dig = hi ? t5[3:0] + 4'd6 : t5[3:0];
    c = hi;
    bad = ad > 4'd9 || bo > 4'd9;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k <= '0;
      ra <= '0;
      rb <= '0;
      carry <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      invalid <= 1'b0;
    end else if (accept) begin
      k <= '0;
      ra <= a;
      rb <= b;
      carry <= cin_in;
      sum <= '0;
      invalid <= 1'b0;
    end else if (state == RUN) begin
      k <= k + 1'b1;
      sum[4*k +: 4] <= dig;
      carry <= c;
      invalid <= invalid | bad;
      if (last) cout <= c;
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed self-checking bench for bcd_serial_adder (DIGITS=4)
module tb_bcd_serial_adder;
  logic clk = 0, rst = 1, start = 0, cin = 0, sub = 0;
  logic [15:0] a = 0, b = 0, sum;
  logic busy, done, cout, invalid;
  int checks = 0, failures = 0;
  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );
  always #5 clk = ~clk;

  task automatic run_op(input logic [15:0] av, bv, input logic ci, sb, output int lat, output int bc);
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; start = 1;
    @(negedge clk);
    start = 0;
    lat = 1; bc = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (busy !== 0 || done !== 0) begin failures++; $display("FAIL reset_hs busy=%b done=%b want 0 0", busy, done); end
    checks++; if (sum !== 16'h0 || cout !== 0 || invalid !== 0) begin failures++; $display("FAIL reset_out sum=%h cout=%b inv=%b want 0000 0 0", sum, cout, invalid); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_basic;
    int lat, bc;
    run_op(16'h1234, 16'h5678, 0, 0, lat, bc);
    checks++; if (lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d want=5", lat); end
    checks++; if (bc !== 4) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=4", bc); end
    checks++; if (sum !== 16'h6912 || cout !== 0 || invalid !== 0) begin failures++; $display("FAIL basic_result sum=%h cout=%b inv=%b want 6912 0 0", sum, cout, invalid); end
    @(negedge clk);
    checks++; if (done !== 0 || sum !== 16'h6912) begin failures++; $display("FAIL basic_done_pulse done=%b sum=%h want 0 6912", done, sum); end
  endtask

  task automatic test_carry;
    int lat, bc;
    run_op(16'h9999, 16'h0001, 0, 0, lat, bc);
    checks++; if (sum !== 16'h0000 || cout !== 1) begin failures++; $display("FAIL carry_ripple sum=%h cout=%b want 0000 1", sum, cout); end
    run_op(16'h9999, 16'h9999, 1, 0, lat, bc);
    checks++; if (sum !== 16'h9999 || cout !== 1) begin failures++; $display("FAIL carry_max sum=%h cout=%b want 9999 1", sum, cout); end
  endtask

  task automatic test_invalid;
    int lat, bc;
    run_op(16'h00A0, 16'h0000, 0, 0, lat, bc);
    checks++; if (sum !== 16'h0100 || cout !== 0 || invalid !== 1) begin failures++; $display("FAIL invalid_op sum=%h cout=%b inv=%b want 0100 0 1", sum, cout, invalid); end
    @(negedge clk);
    checks++; if (invalid !== 1) begin failures++; $display("FAIL invalid_sticky inv=%b want 1", invalid); end
    run_op(16'h0001, 16'h0001, 0, 0, lat, bc);
    checks++; if (sum !== 16'h0002 || invalid !== 0) begin failures++; $display("FAIL invalid_clear sum=%h inv=%b want 0002 0", sum, invalid); end
  endtask

  task automatic test_reset_mid_run;
    int lat, bc, dn = 0;
    run_op(16'h9999, 16'h0001, 0, 0, lat, bc);
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++; if (busy !== 0 || done !== 0 || sum !== 16'h0 || cout !== 0) begin failures++; $display("FAIL rst_mid busy=%b done=%b sum=%h cout=%b want 0 0 0000 0", busy, done, sum, cout); end
    @(negedge clk); rst = 0;
    repeat (8) begin @(negedge clk); if (done) dn++; end
    checks++; if (dn !== 0) begin failures++; $display("FAIL rst_no_done pulses=%0d want=0", dn); end
  endtask

  task automatic test_start_ignored;
    int lat = 1;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1; start = 1;
    @(negedge clk);
    start = 0;
    lat = 3;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 5) begin failures++; $display("FAIL ignore_latency got=%0d want=5", lat); end
    checks++; if (sum !== 16'h6912 || cout !== 0) begin failures++; $display("FAIL ignore_result sum=%h cout=%b want 6912 0", sum, cout); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int pos[$];
    int bad = 0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; cin = 0; start = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) begin pos.push_back(i); if (sum !== 16'h0003 || busy) bad++; end
    end
    start = 0;
    checks++; if (pos.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d want=3", pos.size()); end
    else begin
      checks++; if (pos[0] !== 4 || pos[1] !== 9 || pos[2] !== 14) begin failures++; $display("FAIL b2b_spacing got=%0d,%0d,%0d want=4,9,14", pos[0], pos[1], pos[2]); end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_result bad_pulses=%0d want=0", bad); end
    repeat (6) @(negedge clk);
    checks++; if (busy !== 0 || done !== 0) begin failures++; $display("FAIL b2b_idle busy=%b done=%b want 0 0", busy, done); end
  endtask

`ifdef BCD_SUB_EN
  task automatic test_sub;
    int lat, bc;
    run_op(16'h0500, 16'h0123, 0, 1, lat, bc);
    checks++; if (sum !== 16'h0377 || cout !== 1) begin failures++; $display("FAIL sub_pos sum=%h cout=%b want 0377 1", sum, cout); end
    run_op(16'h0123, 16'h0500, 1, 1, lat, bc);
    checks++; if (sum !== 16'h9623 || cout !== 0) begin failures++; $display("FAIL sub_neg sum=%h cout=%b want 9623 0", sum, cout); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_invalid;
    test_reset_mid_run;
    test_start_ignored;
    test_back_to_back;
`ifdef BCD_SUB_EN
    test_sub;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
